// File: rtl/spi_reg_pkg.sv
// Shared widths, command-byte layout, FSM encoding and debug view for the SPI register bridge.
package spi_reg_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 8;
  localparam int CMD_WR_BIT = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    DATA_WR = 2'd2,
    DATA_RD = 2'd3
  } state_t;

  // Debug view of the bridge: FSM state, bit position and synchronized pin activity.
  typedef struct packed {
    state_t     state;
    logic [2:0] bit_cnt;
    logic       sclk_s;
    logic       frame_end;
  } dbg_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns command/data frames into single-cycle register-bus read/write strobes.
// Register bus: read/write are one-cycle strobes, never together; addr is stable while either is high and data_read is sampled in the read cycle.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_write,
  input  logic [DATA_W-1:0] data_read,
  output dbg_t              dbg
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_s1, mosi_sync;

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] rx_shift, tx_shift, rx_next;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .din(cs_n),
    .sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_s1   <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      mosi_s1   <= mosi;
      mosi_sync <= mosi_s1;
    end
  end

  assign rx_next = {rx_shift[DATA_W-2:0], mosi_sync};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      addr       <= '0;
      data_write <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
    end else begin
      read  <= 1'b0;
      write <= 1'b0;
      // Loads use the data_read presented during the read strobe cycle.
      if (read)
        tx_shift <= data_read;
      if (write)
        addr <= addr + ADDR_ONE;
      if (cs_sync) begin
        state    <= IDLE;
        bit_cnt  <= 3'd0;
        rx_shift <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state    <= CMD;
              bit_cnt  <= 3'd0;
              rx_shift <= '0;
            end
          end
          default: begin
            if (sclk_rise) begin
              rx_shift <= rx_next;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                case (state)
                  CMD: begin
                    addr <= rx_next[ADDR_W-1:0];
                    if (rx_next[CMD_WR_BIT]) begin
                      state <= DATA_WR;
                    end else begin
                      state <= DATA_RD;
                      read  <= 1'b1;
                    end
                  end
                  DATA_WR: begin
                    data_write <= rx_next;
                    write      <= 1'b1;
                  end
                  DATA_RD: begin
                    addr <= addr + ADDR_ONE;
                    read <= 1'b1;
                  end
                  default: ;
                endcase
              end
            end
            // The falling edge right after a byte boundary must not shift out the freshly loaded MSB.
            if (sclk_fall && state == DATA_RD && bit_cnt != 3'd0)
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
          end
        endcase
      end
    end
  end

  assign miso = (state == DATA_RD) ? tx_shift[DATA_W-1] : 1'b0;

  assign dbg.state     = state;
  assign dbg.bit_cnt   = bit_cnt;
  assign dbg.sclk_s    = sclk_sync;
  assign dbg.frame_end = cs_rise;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: SPI host driver, strobe monitor with expected values, summary report.
module tb_spi_reg_bridge;
  import spi_reg_pkg::*;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n, sclk, cs_n, mosi;
  logic       miso, read, write;
  logic [5:0] addr;
  logic [7:0] data_write, data_read;
  dbg_t       dbg;

  int n_vec = 0;
  int n_err = 0;
  int overlap = 0;

  logic [13:0] wr_q[$];
  logic [5:0]  rd_q[$];
  logic [7:0]  frame_tx[4];
  logic [7:0]  frame_rx[4];
  logic [7:0]  junk;

  spi_reg_bridge dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .read(read), .write(write), .addr(addr),
    .data_write(data_write), .data_read(data_read), .dbg(dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Register file model: a few mapped locations, everything else reads 0x00.
  always_comb begin
    data_read = 8'h00;
    case (addr)
      6'h0C: data_read = 8'h96;
      6'h0D: data_read = 8'hA5;
      6'h08: data_read = 8'h5A;
      default: data_read = 8'h00;
    endcase
  end

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (write) wr_q.push_back({addr, data_write});
    if (read)  rd_q.push_back(addr);
    if (read && write) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: mode 0, mosi set while sclk low, miso sampled at the rising edge.
  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      repeat (HALF) @(posedge clk);
      #2 sclk = 1'b1;
      rx = {rx[6:0], miso};
      repeat (HALF) @(posedge clk);
      #2 sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input int n);
    cs_n = 1'b0;
    for (int k = 0; k < n; k++) xfer_bits(frame_tx[k], 8, frame_rx[k]);
    repeat (6) @(posedge clk);
    #2 cs_n = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic clear_logs();
    wr_q.delete();
    rd_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read", read, 0);
    chk("rst_write", write, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data_write", data_write, 0);
    chk("rst_miso", miso, 0);
    chk("rst_state", dbg.state, IDLE);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;

    // Single write
    clear_logs();
    frame_tx[0] = 8'h80; frame_tx[1] = 8'h34;
    run_frame(2);
    chk("wr1_count", wr_q.size(), 1);
    chk("wr1_txn", wr_q[0], {6'h00, 8'h34});
    chk("wr1_no_read", rd_q.size(), 0);
    chk("wr1_addr_inc", addr, 6'h01);

    // Single read: one strobe at 0x0D, prefetch at 0x0E at the end of the data byte
    clear_logs();
    frame_tx[0] = 8'h0D; frame_tx[1] = 8'h00;
    run_frame(2);
    chk("rd1_miso_cmd", frame_rx[0], 8'h00);
    chk("rd1_miso_data", frame_rx[1], 8'hA5);
    chk("rd1_count", rd_q.size(), 2);
    chk("rd1_addr", rd_q[0], 6'h0D);
    chk("rd1_prefetch", rd_q[1], 6'h0E);
    chk("rd1_no_write", wr_q.size(), 0);

    // Burst write
    clear_logs();
    frame_tx[0] = 8'h83; frame_tx[1] = 8'h11; frame_tx[2] = 8'h22;
    run_frame(3);
    chk("bw_count", wr_q.size(), 2);
    chk("bw_txn0", wr_q[0], {6'h03, 8'h11});
    chk("bw_txn1", wr_q[1], {6'h04, 8'h22});
    chk("bw_final_addr", addr, 6'h05);

    // Burst write across the address wrap (bit6 of command ignored)
    clear_logs();
    frame_tx[0] = 8'hBF; frame_tx[1] = 8'hAA; frame_tx[2] = 8'hBB;
    run_frame(3);
    chk("wrap_count", wr_q.size(), 2);
    chk("wrap_txn0", wr_q[0], {6'h3F, 8'hAA});
    chk("wrap_txn1", wr_q[1], {6'h00, 8'hBB});
    chk("wrap_final_addr", addr, 6'h01);

    // Abort after 5 data bits, then a normal frame
    clear_logs();
    cs_n = 1'b0;
    xfer_bits(8'h82, 8, junk);
    xfer_bits(8'h55, 5, junk);
    repeat (4) @(posedge clk);
    #2 cs_n = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    chk("abort_no_write", wr_q.size(), 0);
    chk("abort_state", dbg.state, IDLE);
    frame_tx[0] = 8'h82; frame_tx[1] = 8'h55;
    run_frame(2);
    chk("after_abort_count", wr_q.size(), 1);
    chk("after_abort_txn", wr_q[0], {6'h02, 8'h55});

    // Burst read with prefetch
    clear_logs();
    frame_tx[0] = 8'h0C; frame_tx[1] = 8'h00; frame_tx[2] = 8'h00;
    run_frame(3);
    chk("br_miso0", frame_rx[1], 8'h96);
    chk("br_miso1", frame_rx[2], 8'hA5);
    chk("br_count", rd_q.size(), 3);
    chk("br_addr0", rd_q[0], 6'h0C);
    chk("br_addr1", rd_q[1], 6'h0D);
    chk("br_addr2", rd_q[2], 6'h0E);

    // Reset in the middle of a data byte
    clear_logs();
    cs_n = 1'b0;
    xfer_bits(8'h85, 8, junk);
    xfer_bits(8'hF0, 4, junk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_read", read, 0);
    chk("mid_rst_write", write, 0);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_data_write", data_write, 0);
    chk("mid_rst_miso", miso, 0);
    chk("mid_rst_state", dbg.state, IDLE);
    cs_n = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    clear_logs();
    frame_tx[0] = 8'h08; frame_tx[1] = 8'h00;
    run_frame(2);
    chk("post_rst_miso", frame_rx[1], 8'h5A);
    chk("post_rst_rd_count", rd_q.size(), 2);
    chk("post_rst_rd_addr", rd_q[0], 6'h08);
    chk("post_rst_no_write", wr_q.size(), 0);

    chk("read_write_overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
